// File: rtl/alu_seq_pkg.sv
// ---------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the execute-stage ALU: WIDTH-independent opcode
// constants and the encoding of the handshake state machine.
// ---------------------------------------------------------------------------
package alu_seq_pkg;

    localparam int OP_W = 5;

    localparam logic [OP_W-1:0] ALU_ADD  = 5'd0;
    localparam logic [OP_W-1:0] ALU_SUB  = 5'd1;
    localparam logic [OP_W-1:0] ALU_AND  = 5'd2;
    localparam logic [OP_W-1:0] ALU_OR   = 5'd3;
    localparam logic [OP_W-1:0] ALU_XOR  = 5'd4;
    localparam logic [OP_W-1:0] ALU_COM  = 5'd5;
    localparam logic [OP_W-1:0] ALU_SWAP = 5'd6;
    localparam logic [OP_W-1:0] ALU_ROR  = 5'd7;
    localparam logic [OP_W-1:0] ALU_ROL  = 5'd8;
    localparam logic [OP_W-1:0] ALU_INC  = 5'd9;
    localparam logic [OP_W-1:0] ALU_DEC  = 5'd10;
    localparam logic [OP_W-1:0] ALU_PA   = 5'd11;
    localparam logic [OP_W-1:0] ALU_PB   = 5'd12;
    localparam logic [OP_W-1:0] ALU_BSF  = 5'd13;
    localparam logic [OP_W-1:0] ALU_BCF  = 5'd14;
    localparam logic [OP_W-1:0] ALU_ZERO = 5'd15;
    localparam logic [OP_W-1:0] ALU_MUL  = 5'd16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// ---------------------------------------------------------------------------
// alu_seq_if
// Request/result bundle between the sequencer (master) and the ALU (slave).
//   master drives: start, op, a, b, cin
//   slave drives : ready, done, y, y_hi, cout, dcout, zout
// ---------------------------------------------------------------------------
interface alu_seq_if
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic             start;
    logic [OP_W-1:0]  op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] y_hi;
    logic             cout;
    logic             dcout;
    logic             zout;

    modport master (
        output start, op, a, b, cin,
        input  ready, done, y, y_hi, cout, dcout, zout
    );

    modport slave (
        input  start, op, a, b, cin,
        output ready, done, y, y_hi, cout, dcout, zout
    );
endinterface

// File: rtl/alu_seq_mul_seq.sv
// ---------------------------------------------------------------------------
// mul_seq
// Unsigned shift-add multiplier, one partial product per clock.
//   load : latch a/b and start; must only be pulsed while not busy
//   a, b : operands (sampled on load)
//   busy : iterations in progress
//   fin  : the current clock performs the last iteration
//   prod : product including the current iteration; complete when busy & fin
// A load at edge E0 is followed by WIDTH iterations at E1..E(WIDTH).
// ---------------------------------------------------------------------------
module mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               fin,
    output logic [2*WIDTH-1:0] prod
);
    localparam int CNT_W = $clog2(WIDTH);

    logic                 busy_q, busy_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   acc_next;

    assign fin  = (cnt_q == CNT_W'(WIDTH - 1));
    assign busy = busy_q;
    // Exposing the accumulator including this clock's partial product lets
    // the owner register the finished product on the last iteration edge.
    assign prod = acc_next;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        if (load) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
        end else if (busy_q) begin
            acc_d    = acc_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (fin) begin
                busy_d = 1'b0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end
endmodule

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
// Registered execute-stage ALU with a multi-cycle unsigned multiply.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : alu_seq_if.slave (start/op/a/b/cin in; ready/done/y/y_hi/
//                cout/dcout/zout out)
// Single-cycle ops complete one clock after acceptance and may issue every
// clock. MUL holds ready low for WIDTH clocks; results hold until next done.
// WIDTH must be even and at least 8.
// ---------------------------------------------------------------------------
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic    clk,
    input  logic    rst_n,
    alu_seq_if.slave bus
);
    state_t             state_q, state_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic [WIDTH-1:0]   y_hi_q, y_hi_d;
    logic               cout_q, cout_d;
    logic               dcout_q, dcout_d;
    logic               zout_q, zout_d;

    logic               accept;
    logic               mul_load, mul_busy, mul_fin, mul_last;
    logic [2*WIDTH-1:0] mul_prod;

    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   sc_y;
    logic               sc_cout, sc_dcout;

    assign accept   = bus.start && (state_q == ST_IDLE);
    assign mul_load = accept && (bus.op == ALU_MUL);
    assign mul_last = mul_busy && mul_fin;

    mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (mul_load),
        .a     (bus.a),
        .b     (bus.b),
        .busy  (mul_busy),
        .fin   (mul_fin),
        .prod  (mul_prod)
    );

    // Single-cycle result and flags.
    always_comb begin
        sum      = '0;
        sc_y     = '0;
        sc_cout  = 1'b0;
        sc_dcout = 1'b0;
        case (bus.op)
            ALU_ADD: begin
                sum      = {1'b0, bus.a} + {1'b0, bus.b};
                sc_y     = sum[WIDTH-1:0];
                sc_cout  = sum[WIDTH];
                // Carry into bit 4 recovered from the sum and operand bits.
                sc_dcout = sum[4] ^ bus.a[4] ^ bus.b[4];
            end
            ALU_SUB: begin
                sum      = {1'b0, bus.b} - {1'b0, bus.a};
                sc_y     = sum[WIDTH-1:0];
                sc_cout  = ~sum[WIDTH];
                sc_dcout = (bus.b[3:0] >= bus.a[3:0]);
            end
            ALU_AND:  sc_y = bus.a & bus.b;
            ALU_OR:   sc_y = bus.a | bus.b;
            ALU_XOR:  sc_y = bus.a ^ bus.b;
            ALU_COM:  sc_y = ~bus.b;
            ALU_SWAP: sc_y = {bus.b[WIDTH/2-1:0], bus.b[WIDTH-1:WIDTH/2]};
            ALU_ROR: begin
                sc_y    = {bus.cin, bus.b[WIDTH-1:1]};
                sc_cout = bus.b[0];
            end
            ALU_ROL: begin
                sc_y    = {bus.b[WIDTH-2:0], bus.cin};
                sc_cout = bus.b[WIDTH-1];
            end
            ALU_INC:  sc_y = bus.b + 1'b1;
            ALU_DEC:  sc_y = bus.b - 1'b1;
            ALU_PA:   sc_y = bus.a;
            ALU_PB:   sc_y = bus.b;
            ALU_BSF:  sc_y = bus.a | bus.b;
            ALU_BCF:  sc_y = ~bus.a & bus.b;
            default:  sc_y = '0;
        endcase
    end

    // Handshake FSM and output register next-state.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        y_d     = y_q;
        y_hi_d  = y_hi_q;
        cout_d  = cout_q;
        dcout_d = dcout_q;
        zout_d  = zout_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (bus.op == ALU_MUL) begin
                        state_d = ST_BUSY;
                    end else begin
                        y_d     = sc_y;
                        y_hi_d  = '0;
                        cout_d  = sc_cout;
                        dcout_d = sc_dcout;
                        zout_d  = (sc_y == '0);
                        done_d  = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                if (mul_last) begin
                    y_d     = mul_prod[WIDTH-1:0];
                    y_hi_d  = mul_prod[2*WIDTH-1:WIDTH];
                    cout_d  = 1'b0;
                    dcout_d = 1'b0;
                    zout_d  = (mul_prod == '0);
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            y_q     <= '0;
            y_hi_q  <= '0;
            cout_q  <= 1'b0;
            dcout_q <= 1'b0;
            zout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            y_q     <= y_d;
            y_hi_q  <= y_hi_d;
            cout_q  <= cout_d;
            dcout_q <= dcout_d;
            zout_q  <= zout_d;
        end
    end

    assign bus.ready = (state_q == ST_IDLE);
    assign bus.done  = done_q;
    assign bus.y     = y_q;
    assign bus.y_hi  = y_hi_q;
    assign bus.cout  = cout_q;
    assign bus.dcout = dcout_q;
    assign bus.zout  = zout_q;
endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq
// Drives an 8-bit and a 16-bit alu_seq and compares every result against an
// arithmetic reference model of the opcode table.
// ---------------------------------------------------------------------------
module tb_alu_seq;
    import alu_seq_pkg::*;

    typedef struct {
        longint unsigned y;
        longint unsigned y_hi;
        bit              c;
        bit              dc;
        bit              z;
    } res_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    res_t last8;

    alu_seq_if #(.WIDTH(8))  bus8 ();
    alu_seq_if #(.WIDTH(16)) bus16 ();

    alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    alu_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input longint unsigned exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: opcode table evaluated with plain integer arithmetic.
    function automatic res_t model(input int w, input logic [4:0] op,
                                   input longint unsigned a, input longint unsigned b,
                                   input bit cin);
        res_t r;
        longint unsigned mask = (64'd1 << w) - 1;
        longint unsigned half = (64'd1 << (w / 2)) - 1;
        longint unsigned s;
        r.y = 0; r.y_hi = 0; r.c = 0; r.dc = 0;
        case (op)
            ALU_ADD: begin
                s    = a + b;
                r.y  = s & mask;
                r.c  = (s >> w) != 0;
                r.dc = ((a & 15) + (b & 15)) > 15;
            end
            ALU_SUB: begin
                r.y  = (b - a) & mask;
                r.c  = b >= a;
                r.dc = (b & 15) >= (a & 15);
            end
            ALU_AND:  r.y = a & b;
            ALU_OR:   r.y = a | b;
            ALU_XOR:  r.y = a ^ b;
            ALU_COM:  r.y = ~b & mask;
            ALU_SWAP: r.y = ((b & half) << (w / 2)) | (b >> (w / 2));
            ALU_ROR: begin
                r.y = (longint'(cin) << (w - 1)) | (b >> 1);
                r.c = b[0];
            end
            ALU_ROL: begin
                r.y = ((b << 1) | longint'(cin)) & mask;
                r.c = ((b >> (w - 1)) & 1) != 0;
            end
            ALU_INC:  r.y = (b + 1) & mask;
            ALU_DEC:  r.y = (b - 1) & mask;
            ALU_PA:   r.y = a;
            ALU_PB:   r.y = b;
            ALU_BSF:  r.y = a | b;
            ALU_BCF:  r.y = ~a & b & mask;
            ALU_ZERO: r.y = 0;
            ALU_MUL: begin
                s      = a * b;
                r.y    = s & mask;
                r.y_hi = s >> w;
            end
            default:  r.y = 0;
        endcase
        r.z = (r.y == 0) && (r.y_hi == 0);
        return r;
    endfunction

    task automatic check_res8(input res_t e);
        check("y8", bus8.y, e.y);
        check("y_hi8", bus8.y_hi, e.y_hi);
        check("cout8", bus8.cout, e.c);
        check("dcout8", bus8.dcout, e.dc);
        check("zout8", bus8.zout, e.z);
    endtask

    task automatic check_res16(input res_t e);
        check("y16", bus16.y, e.y);
        check("y_hi16", bus16.y_hi, e.y_hi);
        check("cout16", bus16.cout, e.c);
        check("dcout16", bus16.dcout, e.dc);
        check("zout16", bus16.zout, e.z);
    endtask

    // Issue one op on the 8-bit DUT (called just after a rising edge while idle).
    task automatic run_op8(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic cin);
        res_t e;
        int   lat;
        e = model(8, op, a, b, cin);
        bus8.start = 1'b1; bus8.op = op; bus8.a = a; bus8.b = b; bus8.cin = cin;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        if (op == ALU_MUL) begin
            lat = 0;
            while (!bus8.done && lat < 40) begin
                check("mul_ready_low", bus8.ready, 0);
                check("mul_hold_y", bus8.y, last8.y);
                check("mul_hold_z", bus8.zout, last8.z);
                // Inputs are free to change and start is ignored while busy.
                bus8.a     = 8'($urandom);
                bus8.b     = 8'($urandom);
                bus8.op    = 5'($urandom_range(0, 16));
                bus8.start = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                lat++;
            end
            bus8.start = 1'b0;
            check("mul_latency8", lat, 8);
        end
        check("done8", bus8.done, 1);
        check("ready8", bus8.ready, 1);
        check_res8(e);
        last8 = e;
    endtask

    task automatic idle8();
        bus8.start = 1'b0;
        @(posedge clk); #1;
        check("idle_done8", bus8.done, 0);
        check("idle_hold_y8", bus8.y, last8.y);
    endtask

    task automatic check_reset_vals();
        check("rst_ready8", bus8.ready, 1);
        check("rst_done8", bus8.done, 0);
        check("rst_y8", bus8.y, 0);
        check("rst_y_hi8", bus8.y_hi, 0);
        check("rst_cout8", bus8.cout, 0);
        check("rst_dcout8", bus8.dcout, 0);
        check("rst_zout8", bus8.zout, 0);
    endtask

    initial begin
        res_t e;
        logic [4:0]  op;
        logic [15:0] a16, b16;
        logic        c16;
        int          lat;

        bus8.start = 0; bus8.op = 0; bus8.a = 0; bus8.b = 0; bus8.cin = 0;
        bus16.start = 0; bus16.op = 0; bus16.a = 0; bus16.b = 0; bus16.cin = 0;
        last8.y = 0; last8.y_hi = 0; last8.c = 0; last8.dc = 0; last8.z = 0;

        #2;
        check_reset_vals();
        check("rst_ready16", bus16.ready, 1);
        check("rst_y16", bus16.y, 0);
        check("rst_zout16", bus16.zout, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases with literal expectations.
        run_op8(ALU_ADD, 8'hF8, 8'h0A, 1'b0);
        check("tp_add_y", bus8.y, 8'h02);
        check("tp_add_c", bus8.cout, 1);
        check("tp_add_dc", bus8.dcout, 1);
        idle8();
        run_op8(ALU_SUB, 8'h05, 8'h05, 1'b0);
        check("tp_sub_eq_z", bus8.zout, 1);
        check("tp_sub_eq_c", bus8.cout, 1);
        run_op8(ALU_SUB, 8'h06, 8'h05, 1'b0);
        check("tp_sub_lt_y", bus8.y, 8'hFF);
        check("tp_sub_lt_c", bus8.cout, 0);
        check("tp_sub_lt_dc", bus8.dcout, 0);
        run_op8(ALU_MUL, 8'hFF, 8'hFF, 1'b0);
        check("tp_mul_prod", {bus8.y_hi, bus8.y}, 16'hFE01);
        run_op8(ALU_ROR, 8'h00, 8'h01, 1'b1);
        check("tp_ror_y", bus8.y, 8'h80);
        check("tp_ror_c", bus8.cout, 1);
        run_op8(ALU_ROL, 8'h00, 8'h80, 1'b0);
        check("tp_rol_z", bus8.zout, 1);
        check("tp_rol_c", bus8.cout, 1);
        run_op8(5'd31, 8'h12, 8'h34, 1'b1);
        check("tp_bad_op_z", bus8.zout, 1);

        // Reset during cycle 4 of a MUL, then start while in reset.
        bus8.start = 1'b1; bus8.op = ALU_MUL; bus8.a = 8'h37; bus8.b = 8'h5C;
        @(posedge clk); #1;
        bus8.start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_reset_vals();
        bus8.start = 1'b1; bus8.op = ALU_ADD; bus8.a = 8'h01; bus8.b = 8'h01;
        @(posedge clk); #1;
        check("rst_wins_done", bus8.done, 0);
        check("rst_wins_y", bus8.y, 0);
        bus8.start = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_done", bus8.done, 0);
        check("post_rst_ready", bus8.ready, 1);
        last8.y = 0; last8.y_hi = 0; last8.c = 0; last8.dc = 0; last8.z = 0;
        run_op8(ALU_ADD, 8'h01, 8'h01, 1'b0);
        check("tp_post_rst_add", bus8.y, 8'h02);

        // Randomized mix on the 8-bit DUT, MUL and invalid codes included.
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) idle8();
            else run_op8(5'($urandom_range(0, 19)), 8'($urandom), 8'($urandom),
                         1'($urandom));
        end

        // 16-bit: start held high, one op per clock.
        bus16.start = 1'b1; bus16.op = ALU_SWAP; bus16.b = 16'h1234;
        @(posedge clk); #1;
        check("tp_swap16", bus16.y, 16'h3412);
        check("tp_swap16_done", bus16.done, 1);
        bus16.op = ALU_INC; bus16.b = 16'hFFFF;
        @(posedge clk); #1;
        check("tp_inc16", bus16.y, 16'h0000);
        check("tp_inc16_z", bus16.zout, 1);
        check("tp_inc16_done", bus16.done, 1);
        bus16.op = ALU_DEC; bus16.b = 16'h0000;
        @(posedge clk); #1;
        check("tp_dec16", bus16.y, 16'hFFFF);
        check("tp_dec16_done", bus16.done, 1);
        for (int i = 0; i < 40; i++) begin
            op = 5'($urandom_range(0, 20));
            if (op == ALU_MUL) op = 5'd31;
            a16 = 16'($urandom); b16 = 16'($urandom); c16 = 1'($urandom);
            bus16.op = op; bus16.a = a16; bus16.b = b16; bus16.cin = c16;
            e = model(16, op, a16, b16, c16);
            @(posedge clk); #1;
            check("b2b_done16", bus16.done, 1);
            check_res16(e);
        end
        bus16.start = 1'b0;
        @(posedge clk); #1;
        check("idle_done16", bus16.done, 0);

        // 16-bit MUL latency and product.
        bus16.start = 1'b1; bus16.op = ALU_MUL; bus16.a = 16'hFFFF; bus16.b = 16'hFFFF;
        @(posedge clk); #1;
        bus16.start = 1'b0;
        lat = 0;
        while (!bus16.done && lat < 60) begin
            check("mul16_ready_low", bus16.ready, 0);
            @(posedge clk); #1;
            lat++;
        end
        check("mul_latency16", lat, 16);
        check("mul16_prod", {bus16.y_hi, bus16.y}, 32'hFFFE0001);
        check("mul16_ready", bus16.ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the single-cycle 8-bit datapath ALU, used in the core's execute stage. It adds a WIDTH parameter, a digit-carry flag and a multi-cycle unsigned multiply. A start/ready/done handshake lets the sequencer stall only on multi-cycle operations. Single-cycle operations can be issued back-to-back, one per clock.

## Interface
- WIDTH, 8: datapath width. Must be even and ≥ 8.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  request. Accepted on a rising edge when start=1 and ready=1.
- op  in  5  operation code, from the shared ALU opcode constants.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B, the file-register operand.
- cin  in  1  carry in, used by ROR and ROL.
- ready  out  1  high in IDLE (combinational from state).
- done  out  1  one-cycle pulse when new results are visible.
- y  out  WIDTH  result, or the low half of the product for MUL.
- y_hi  out  WIDTH  high half of the product for MUL; 0 for all other ops.
- cout  out  1  carry / not-borrow flag.
- dcout  out  1  digit carry: carry out of bit 3.
- zout  out  1  zero flag.

## Operation
- Opcodes:
  - ADD=0: y=a+b.
  - SUB=1: y=b-a.
  - AND=2, OR=3, XOR=4: bitwise a op b.
  - COM=5: y=~b.
  - SWAP=6: exchange the halves of b.
  - ROR=7: {cout,y}={b[0],cin,b[W-1:1]}.
  - ROL=8: {cout,y}={b[W-1],b[W-2:0],cin}.
  - INC=9: y=b+1. DEC=10: y=b-1.
  - PA=11: y=a. PB=12: y=b.
  - BSF=13: y=a|b. BCF=14: y=~a&b.
  - ZERO=15: y=0.
  - MUL=16: {y_hi,y}=a*b, unsigned.
  - Any other code: y=0, y_hi=0, cout=0, dcout=0, zout=1.
- Arithmetic: sums are WIDTH+1 bits wide. INC and DEC wrap modulo 2^WIDTH.
- cout:
  - ADD: carry out.
  - SUB: inverted borrow, so cout=1 when b≥a.
  - ROR, ROL: the bit shifted out.
  - All other ops: 0.
- dcout:
  - ADD: carry out of bit 3.
  - SUB: 1 when b[3:0]≥a[3:0].
  - All other ops: 0.
- zout: (y==0) for all ops; ({y_hi,y}==0) for MUL.
- Operands, op and cin are sampled only at acceptance. MUL latches them internally, so inputs may change while busy.
- All outputs are registered and hold their values until the next done.
- State machine:
  - IDLE→IDLE on acceptance of a non-MUL op.
  - IDLE→BUSY on acceptance of MUL.
  - BUSY→IDLE after WIDTH iterations.
- start while BUSY is ignored: no queueing, no error.

## Timing
- Reset values: state=IDLE, ready=1, done=0, y=0, y_hi=0, cout=0, dcout=0, zout=0.
- Single-cycle op accepted at edge E0: results and done=1 appear after E0, so latency is 1. ready stays 1, so start held high issues one op per clock and done stays high.
- MUL accepted at E0:
  - ready=0 from after E0 until after EW.
  - One shift-add iteration at each of E1..EW.
  - Product, flags and done=1 appear after EW. Latency is WIDTH cycles.
  - ready=1 again after EW, so a new start may be accepted at EW+1.
  - y, y_hi and flags keep their previous values until EW.
- done is never high while ready=0.
- Reset mid-MUL: immediate return to the reset values. The partial product is discarded and done is not asserted.
- Simultaneous start and reset: reset wins.

## Structure
- Add WIDTH-independent opcode constants ALU_* to the shared definitions header/package, including the new ALU_MUL=16. Add the state encoding (IDLE/BUSY) there as well.
- Sub-module mul_seq, parametrised by WIDTH:
  - Unsigned shift-add multiplier.
  - Ports: load, a, b, busy, fin, prod[2W-1:0].
  - alu_seq owns the handshake, flags and output registers.
- The single-cycle result/flag logic is one combinational case inside alu_seq.

## Test plan
- ADD, WIDTH=8, a=F8, b=0A → one cycle later y=02, cout=1, dcout=1, zout=0, done pulse.
- SUB a=05, b=05 → y=00, cout=1, dcout=1, zout=1. Then SUB a=06, b=05 → y=FF, cout=0, dcout=0.
- MUL a=FF, b=FF → ready low for 8 cycles, then {y_hi,y}=FE01 with done exactly 8 cycles after acceptance. A start pulse with op=ADD at busy cycle 3 is ignored.
- ROR b=01, cin=1 → y=80, cout=1. Then ROL b=80, cin=0 → y=00, cout=1, zout=1.
- Assert rst_n=0 during cycle 4 of a MUL → all outputs return to reset values and ready=1. A following ADD a=01, b=01 gives y=02.
- WIDTH=16, start held high for SWAP b=1234, INC b=FFFF, DEC b=0000 → y=3412, then 0000 (zout=1), then FFFF; done high for 3 consecutive cycles.
